array_eval_sequencer: RTL and testbench

- Sequences one fitness evaluation of the evolvable logic-cell array for the GA flow.
- First, it streams a genome (cell configuration) into the array's serial config chain.
- Next, it sweeps all 2^N_IN input vectors through the combinational array and waits a fixed settle time per vector.
- For each vector it compares the array output against a target truth table, then reports the match count as fitness.
- Sits between the GA host interface and the array fabric in fpga_main.

---
 rtl/array_eval_sequencer.sv | 160 ++++++++++++++++
 tb/tb_array_eval_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_eval_sequencer.sv
// Loads a genome into the array config chain, sweeps all input vectors and scores the array output
// against a target truth table. Optional MISMATCH_LOG_EN adds a per-vector mismatch_map output.
module array_eval_sequencer #(
  parameter int N_IN    = 4,
  parameter int CFG_LEN = 64,
  parameter int CFG_W   = 8,
  parameter int SETTLE  = 4
) (
  input  logic                 FPGA_CLK_50,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [CFG_W-1:0]     cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2**N_IN-1:0]   target,
  output logic                 arr_cfg_bit,
  output logic                 arr_cfg_shift,
  output logic [N_IN-1:0]      arr_in,
  input  logic                 arr_out,
  output logic                 busy,
  output logic                 done,
`ifdef MISMATCH_LOG_EN
  output logic [2**N_IN-1:0]   mismatch_map,
`endif
  output logic [N_IN:0]        fitness
);

  localparam int NV      = 2**N_IN;
  localparam int N_WORDS = CFG_LEN / CFG_W;
  localparam int BCW     = $clog2(CFG_LEN + 1);
  localparam int WCW     = $clog2(N_WORDS + 1);
  localparam int SHW     = $clog2(CFG_W + 1);
  localparam int SCW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [BCW-1:0]  LAST_BIT    = BCW'(CFG_LEN - 1);
  localparam logic [WCW-1:0]  ALL_WORDS   = WCW'(N_WORDS);
  localparam logic [SHW-1:0]  SH_FULL     = SHW'(CFG_W);
  localparam logic [SHW-1:0]  SH_ONE      = SHW'(1);
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [N_IN:0]   LAST_VEC    = (N_IN+1)'(NV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, FIN} state_t;

  state_t              state_reg, state_next;
  logic [NV-1:0]       target_q;
  logic [CFG_W-1:0]    sh_data;
  logic [SHW-1:0]      sh_cnt;
  logic [BCW-1:0]      bit_cnt;
  logic [WCW-1:0]      word_cnt;
  logic [N_IN:0]       vec;
  logic [SCW-1:0]      settle_cnt;
  logic                accept_start;
  logic                sample;
  logic                handshake;

  always_ff @(posedge FPGA_CLK_50 or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    cfg_ready     = 1'b0;
    arr_cfg_shift = 1'b0;
    accept_start  = 1'b0;
    sample        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        // Ready on the last shift cycle too, so consecutive words stream gap-free.
        cfg_ready     = (sh_cnt <= SH_ONE) && (word_cnt < ALL_WORDS);
        arr_cfg_shift = (sh_cnt != '0);
        if (arr_cfg_shift && (bit_cnt == LAST_BIT)) state_next = EVAL;
      end
      EVAL: begin
        busy   = 1'b1;
        sample = (settle_cnt == SETTLE_LAST);
        if (sample && (vec == LAST_VEC)) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign handshake   = cfg_valid && cfg_ready;
  assign arr_cfg_bit = sh_data[0];
  assign arr_in      = vec[N_IN-1:0];

  always_ff @(posedge FPGA_CLK_50 or posedge RESET) begin
    if (RESET) begin
      target_q   <= '0;
      sh_data    <= '0;
      sh_cnt     <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      vec        <= '0;
      settle_cnt <= '0;
      fitness    <= '0;
    end else begin
      if (accept_start) begin
        target_q   <= target;
        sh_data    <= '0;
        sh_cnt     <= '0;
        bit_cnt    <= '0;
        word_cnt   <= '0;
        vec        <= '0;
        settle_cnt <= '0;
        fitness    <= '0;
      end

      if (handshake) begin
        sh_data  <= cfg_data;
        sh_cnt   <= SH_FULL;
        word_cnt <= word_cnt + 1'b1;
      end else if (arr_cfg_shift) begin
        sh_cnt <= sh_cnt - 1'b1;
        // Hold the final bit in place so a stall leaves arr_cfg_bit stable.
        if (sh_cnt != SH_ONE) sh_data <= sh_data >> 1;
      end

      if (arr_cfg_shift) bit_cnt <= bit_cnt + 1'b1;

      if (state_reg == EVAL) begin
        if (sample) begin
          settle_cnt <= '0;
          vec        <= vec + 1'b1;
          if (arr_out == target_q[vec[N_IN-1:0]]) fitness <= fitness + 1'b1;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end

      if (state_reg == FIN) vec <= '0;
    end
  end

`ifdef MISMATCH_LOG_EN
  always_ff @(posedge FPGA_CLK_50 or posedge RESET) begin
    if (RESET) begin
      mismatch_map <= '0;
    end else if (accept_start) begin
      mismatch_map <= '0;
    end else if ((state_reg == EVAL) && sample && (arr_out != target_q[vec[N_IN-1:0]])) begin
      mismatch_map[vec[N_IN-1:0]] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_array_eval_sequencer.sv
// Bench for array_eval_sequencer: a 64-bit chain model feeds arr_out; runs are scored against a truth-table reference.
module tb_array_eval_sequencer;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] target;
  logic        arr_cfg_bit;
  logic        arr_cfg_shift;
  logic [3:0]  arr_in;
  logic        arr_out;
  logic        busy;
  logic        done;
  logic [4:0]  fitness;
`ifdef MISMATCH_LOG_EN
  logic [15:0] mismatch_map;
`endif

  logic [63:0] chain;
  bit          mode;
  int          checks = 0;
  int          errors = 0;

  array_eval_sequencer dut (
    .FPGA_CLK_50  (clk),
    .RESET        (rst),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .target       (target),
    .arr_cfg_bit  (arr_cfg_bit),
    .arr_cfg_shift(arr_cfg_shift),
    .arr_in       (arr_in),
    .arr_out      (arr_out),
    .busy         (busy),
    .done         (done),
`ifdef MISMATCH_LOG_EN
    .mismatch_map (mismatch_map),
`endif
    .fitness      (fitness)
  );

  always #10 clk = ~clk;

  // Array model: serial chain, first bit in ends up at bit 0 after a full load.
  always @(posedge clk) if (arr_cfg_shift) chain <= {arr_cfg_bit, chain[63:1]};
  assign arr_out = (^arr_in) ^ (mode & chain[arr_in]);

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cur_mm();
`ifdef MISMATCH_LOG_EN
    return mismatch_map;
`else
    return 16'h0;
`endif
  endfunction

  // One start/load/eval run; rst_vec >= 0 asserts RESET while arr_in equals that vector.
  task automatic run(input logic [15:0] tgt, input logic [63:0] genome, input int stall_word,
                     input int stall_len, input bit inj, input int rst_vec,
                     output int fit, output int shifts, output int load_cyc, output int eval_cyc,
                     output int dones, output logic [15:0] mm);
    int widx, scnt, last_shift, done_cyc, rdones;
    bit seen_done, inj_done, stall, finished;
    fit = 0; shifts = 0; load_cyc = 0; eval_cyc = 0; dones = 0; mm = '0;
    widx = 0; scnt = 0; last_shift = -1; done_cyc = 0;
    seen_done = 0; inj_done = 0; finished = 0;
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("fitness_cleared_at_start", fitness, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (rst_vec >= 0 && last_shift >= 0 && !arr_cfg_shift && busy && arr_in == rst_vec[3:0]) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_arr_in", arr_in, 0);
        chk("rst_fitness", fitness, 0);
        @(negedge clk);
        rst = 1'b0;
        cfg_valid = 1'b0;
        rdones = 0;
        for (int k = 0; k < 200; k++) begin
          if (done) rdones++;
          @(negedge clk);
        end
        chk("no_done_after_reset", rdones, 0);
        finished = 1;
        break;
      end
      if (arr_cfg_shift) begin
        shifts++;
        last_shift = cyc;
      end
      if (done) begin
        dones++;
        if (!seen_done) begin
          seen_done = 1;
          done_cyc  = cyc;
          fit       = fitness;
          mm        = cur_mm();
          chk("busy_low_at_done", busy, 0);
        end
      end
      if (seen_done && cyc >= done_cyc + 3) begin
        chk("fitness_held", fitness, fit);
        chk("mismatch_map_held", cur_mm(), mm);
        finished = 1;
        break;
      end
      start = 1'b0;
      if (inj && !inj_done && last_shift >= 0 && cyc == last_shift + 10) begin
        start    = 1'b1;
        inj_done = 1;
      end
      stall = (widx == stall_word) && (scnt < stall_len) && cfg_ready;
      if (stall) scnt++;
      cfg_valid = (widx < 8) && !stall;
      cfg_data  = cfg_valid ? genome[widx*8 +: 8] : 8'h00;
      if (cfg_valid && cfg_ready) widx++;
      @(negedge clk);
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done expected done within 3000 cycles");
    end
    load_cyc = last_shift + 1;
    eval_cyc = done_cyc - last_shift - 1;
  endtask

  typedef struct {
    logic [15:0] tgt;
    int          stall_len;
    bit          inj;
    int          exp_fit;
    logic [15:0] exp_mm;
    int          exp_load;
  } vec_t;

  vec_t tbl[5];
  localparam logic [63:0] GENOME = 64'h0807060504030201;

  initial begin
    int fit, shifts, load_cyc, eval_cyc, dones;
    logic [15:0] mm, rtgt, rmm;
    logic [63:0] rg;
    int rfit, sw, sl;
    bit o;

    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; target = 16'h0; mode = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_cfg_shift", arr_cfg_shift, 0);
    chk("reset_cfg_bit", arr_cfg_bit, 0);
    chk("reset_arr_in", arr_in, 0);
    chk("reset_fitness", fitness, 0);
    chk("reset_mismatch_map", cur_mm(), 0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = '{16'h6996, 0, 0, 16, 16'h0000, 65};
    tbl[1] = '{16'h9669, 0, 0, 0,  16'hFFFF, 65};
    tbl[2] = '{16'h6997, 0, 0, 15, 16'h0001, 65};
    tbl[3] = '{16'h6996, 5, 0, 16, 16'h0000, 70};
    tbl[4] = '{16'h6996, 0, 1, 16, 16'h0000, 65};

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].tgt, GENOME, 3, tbl[i].stall_len, tbl[i].inj, -1,
          fit, shifts, load_cyc, eval_cyc, dones, mm);
      $display("vec %0d tgt=%h fit=%0d shifts=%0d load=%0d eval=%0d dones=%0d chain=%h",
               i, tbl[i].tgt, fit, shifts, load_cyc, eval_cyc, dones, chain);
      chk("tbl_fitness", fit, tbl[i].exp_fit);
      chk("tbl_shifts", shifts, 64);
      chk("tbl_load_cycles", load_cyc, tbl[i].exp_load);
      chk("tbl_eval_cycles", eval_cyc, 64);
      chk("tbl_single_done", dones, 1);
      chk("tbl_chain", chain, GENOME);
`ifdef MISMATCH_LOG_EN
      chk("tbl_mismatch_map", mm, tbl[i].exp_mm);
      chk("tbl_popcount_invariant", fit + $countones(mm), NV);
`endif
    end

    run(16'h6996, GENOME, 3, 0, 0, 7, fit, shifts, load_cyc, eval_cyc, dones, mm);
    $display("reset at vector 7 issued");
    run(16'h6996, GENOME, 3, 0, 0, -1, fit, shifts, load_cyc, eval_cyc, dones, mm);
    $display("post-reset run fit=%0d dones=%0d", fit, dones);
    chk("post_reset_fitness", fit, 16);
    chk("post_reset_single_done", dones, 1);

    mode = 1;
    for (int r = 0; r < 12; r++) begin
      rg   = {$urandom, $urandom};
      rtgt = 16'($urandom);
      sw   = $urandom_range(0, 7);
      sl   = $urandom_range(0, 6);
      rfit = 0;
      rmm  = '0;
      for (int v = 0; v < NV; v++) begin
        o = ($countones(v) % 2 == 1) ^ rg[v];
        if (o == rtgt[v]) rfit++;
        else rmm[v] = 1'b1;
      end
      run(rtgt, rg, sw, sl, 0, -1, fit, shifts, load_cyc, eval_cyc, dones, mm);
      $display("rand %0d tgt=%h genome=%h stall=%0d@%0d fit=%0d exp=%0d load=%0d",
               r, rtgt, rg, sl, sw, fit, rfit, load_cyc);
      chk("rand_fitness", fit, rfit);
      chk("rand_chain", chain, rg);
      chk("rand_load_cycles", load_cyc, 65 + sl);
      chk("rand_eval_cycles", eval_cyc, 64);
`ifdef MISMATCH_LOG_EN
      chk("rand_mismatch_map", mm, rmm);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
